// File: rtl/neuron_mac_seq.sv
// Sequential single-neuron MAC: one shared signed multiplier walks the dim inputs,
// then the bias-seeded sum is shifted back to Q format, saturated and optionally ReLU-clamped.
module neuron_mac_seq #(
  parameter  int unsigned dim   = 2,
  parameter  int unsigned bitw  = 16,
  parameter  int unsigned fracw = 8,
  localparam int unsigned aw    = $clog2(dim + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   w_we_i,
  input  logic [aw-1:0]          w_addr_i,
  input  logic signed [bitw-1:0] w_data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic signed [bitw-1:0] x_i [dim],
  input  logic                   relu_en_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [bitw-1:0]        out_o,
  output logic                   busy_o
);

  localparam int unsigned accw = 2 * bitw + $clog2(dim + 1) + 1;
  localparam int unsigned iw   = (dim > 1) ? $clog2(dim) : 1;
  localparam logic signed [accw-1:0] sat_max = {{(accw - bitw + 1){1'b0}}, {(bitw - 1){1'b1}}};
  localparam logic signed [accw-1:0] sat_min = {{(accw - bitw + 1){1'b1}}, {(bitw - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

  state_e                 state_q, state_d;
  logic signed [bitw-1:0] w_q  [dim];
  logic signed [bitw-1:0] w_d  [dim];
  logic signed [bitw-1:0] wv_q [dim];
  logic signed [bitw-1:0] wv_d [dim];
  logic signed [bitw-1:0] x_q  [dim];
  logic signed [bitw-1:0] x_d  [dim];
  logic signed [bitw-1:0] bias_q, bias_d;
  logic                   relu_q, relu_d;
  logic signed [accw-1:0] acc_q, acc_d;
  logic [iw-1:0]          idx_q, idx_d;
  logic [bitw-1:0]        out_q, out_d;
  logic                   out_valid_q, out_valid_d;
  logic                   in_ready_q, in_ready_d;
  logic                   busy_q, busy_d;

  logic signed [bitw-1:0]   x_sel_c, w_sel_c;
  logic signed [2*bitw-1:0] prod_c;
  logic signed [accw-1:0]   acc_sum_c, shr_c;
  logic [bitw-1:0]          res_c;

  // Operand select, product, running sum and the final Q-format result
  always_comb begin
    x_sel_c = '0;
    w_sel_c = '0;
    for (int unsigned i = 0; i < dim; i++) begin
      if (idx_q == iw'(i)) begin
        x_sel_c = x_q[i];
        w_sel_c = wv_q[i];
      end
    end
    prod_c    = (2 * bitw)'(x_sel_c) * (2 * bitw)'(w_sel_c);
    acc_sum_c = acc_q + accw'(prod_c);
    shr_c     = acc_sum_c >>> fracw;
    if (shr_c > sat_max) begin
      res_c = sat_max[bitw-1:0];
    end else if (shr_c < sat_min) begin
      res_c = sat_min[bitw-1:0];
    end else begin
      res_c = shr_c[bitw-1:0];
    end
    if (relu_q && shr_c[accw-1]) begin
      res_c = '0;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    wv_d        = wv_q;
    x_d         = x_q;
    bias_d      = bias_q;
    relu_d      = relu_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    in_ready_d  = 1'b0;
    busy_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = MAC;
          x_d     = x_i;
          wv_d    = w_q;
          relu_d  = relu_en_i;
          acc_d   = accw'(bias_q) <<< fracw;
          idx_d   = '0;
        end
        // Snapshot above uses pre-write weights, so a same-cycle write only affects later vectors
        if (w_we_i) begin
          for (int unsigned i = 0; i < dim; i++) begin
            if (w_addr_i == aw'(i)) begin
              w_d[i] = w_data_i;
            end
          end
          if (w_addr_i == aw'(dim)) begin
            bias_d = w_data_i;
          end
        end
      end
      MAC: begin
        acc_d = acc_sum_c;
        if (idx_q == iw'(dim - 1)) begin
          state_d     = DONE;
          out_d       = res_c;
          out_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + iw'(1);
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      w_q         <= '{default: '0};
      wv_q        <= '{default: '0};
      x_q         <= '{default: '0};
      bias_q      <= '0;
      relu_q      <= 1'b0;
      acc_q       <= '0;
      idx_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      wv_q        <= wv_d;
      x_q         <= x_d;
      bias_q      <= bias_d;
      relu_q      <= relu_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_o       = out_q;
  assign busy_o      = busy_q;

endmodule
